// File: rtl/rle_encoder.sv
// -----------------------------------------------------------------------------
// rle_encoder
//   JPEG entropy-prep stage placed directly after the zigzag reorder. It takes
//   64 quantised coefficients per 8x8 block in zigzag order. It emits
//   (run, size, amplitude) symbols to the Huffman coder:
//     - the DC differential (always emitted, even when the difference is 0)
//     - AC run/size/amplitude symbols
//     - ZRL (run=15, size=0) for each full group of 16 zeros before a nonzero AC
//     - EOB (run=0, size=0) when the block ends in zeros
//
// Optional feature macro: RLE_DC_RESTART_EN
//   When defined, the design adds input dc_clr. This input clears the DC
//   predictor, which is needed at JPEG restart intervals. A dc_clr that arrives
//   in the same cycle as a DC transfer makes that DC use a predictor of 0.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active-low
//   ena_in   in   input coefficient valid
//   rdy_out  out  encoder can accept a coefficient
//   in       in   signed coefficient, IN_W bits
//   ena_out  out  symbol valid
//   rdy_in   in   Huffman coder can accept a symbol
//   out_dc   out  symbol is the block's DC term
//   out_run  out  zero-run length before this coefficient
//   out_size out  magnitude category (0 = none)
//   out_amp  out  amplitude bits; only the low out_size bits are meaningful
//   dc_clr   in   (RLE_DC_RESTART_EN only) clear the DC predictor
// -----------------------------------------------------------------------------
module rle_encoder #(
  parameter int IN_W   = 10,
  parameter int AMP_W  = IN_W + 1,
  parameter int SIZE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena_in,
  output logic                    rdy_out,
  input  logic signed [IN_W-1:0]  in,
  output logic                    ena_out,
  input  logic                    rdy_in,
  output logic                    out_dc,
  output logic [3:0]              out_run,
  output logic [SIZE_W-1:0]       out_size,
  output logic [AMP_W-1:0]        out_amp
`ifdef RLE_DC_RESTART_EN
  ,
  input  logic                    dc_clr
`endif
);

  typedef enum logic [1:0] {S_IN, S_ZRL, S_EOB} state_t;

  state_t                   state;
  logic [5:0]               idx;
  logic [5:0]               zcnt;
  logic signed [IN_W-1:0]   pred;
  logic [SIZE_W-1:0]        lat_size;
  logic [AMP_W-1:0]         lat_amp;

  logic signed [IN_W-1:0]   pred_eff;
  logic signed [AMP_W-1:0]  in_ext;
  logic signed [AMP_W-1:0]  pred_ext;
  logic signed [AMP_W-1:0]  diff;
  logic [SIZE_W-1:0]        dc_size;
  logic [AMP_W-1:0]         dc_amp;
  logic [SIZE_W-1:0]        ac_size;
  logic [AMP_W-1:0]         ac_amp;
  logic                     out_free;
  logic                     take;

  // Magnitude category: the bit length of |v|. The most negative value maps to
  // its unsigned bit pattern, and that pattern is still the correct magnitude.
  function automatic logic [SIZE_W-1:0] size_of(input logic signed [AMP_W-1:0] v);
    logic [AMP_W-1:0]  mag;
    logic [SIZE_W-1:0] s;
    mag = v[AMP_W-1] ? $unsigned(-v) : $unsigned(v);
    s   = '0;
    for (int i = 0; i < AMP_W; i++) begin
      if (mag[i]) s = SIZE_W'(i + 1);
    end
    return s;
  endfunction

  // JPEG amplitude: v itself when v >= 0. When v < 0, it is v-1, which equals
  // the one's complement of |v| in the low size bits.
  function automatic logic [AMP_W-1:0] amp_of(input logic signed [AMP_W-1:0] v);
    logic [AMP_W-1:0] one;
    one = {{(AMP_W-1){1'b0}}, 1'b1};
    return v[AMP_W-1] ? ($unsigned(v) - one) : $unsigned(v);
  endfunction

`ifdef RLE_DC_RESTART_EN
  assign pred_eff = dc_clr ? '0 : pred;
`else
  assign pred_eff = pred;
`endif

  assign out_free = !ena_out || rdy_in;
  assign rdy_out  = (state == S_IN) && out_free;
  assign take     = ena_in && rdy_out;

  always_comb begin
    in_ext   = AMP_W'(in);
    pred_ext = AMP_W'(pred_eff);
    diff     = in_ext - pred_ext;
    dc_size  = size_of(diff);
    dc_amp   = amp_of(diff);
    ac_size  = size_of(in_ext);
    ac_amp   = amp_of(in_ext);
  end

  // ---- symbol register stage: one holding register feeds the Huffman coder ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IN;
      idx      <= '0;
      zcnt     <= '0;
      pred     <= '0;
      lat_size <= '0;
      lat_amp  <= '0;
      ena_out  <= 1'b0;
      out_dc   <= 1'b0;
      out_run  <= '0;
      out_size <= '0;
      out_amp  <= '0;
    end else begin
`ifdef RLE_DC_RESTART_EN
      if (dc_clr) pred <= '0;
`endif
      case (state)
        S_IN: begin
          if (take) begin
            idx <= idx + 6'd1;
            if (idx == 6'd0) begin
              pred     <= in;
              ena_out  <= 1'b1;
              out_dc   <= 1'b1;
              out_run  <= 4'd0;
              out_size <= dc_size;
              out_amp  <= dc_amp;
            end else if (in == '0) begin
              // Zeros are only counted; a trailing run becomes a single EOB.
              zcnt    <= zcnt + 6'd1;
              ena_out <= 1'b0;
              if (idx == 6'd63) state <= S_EOB;
            end else if (zcnt[5:4] == 2'b00) begin
              ena_out  <= 1'b1;
              out_dc   <= 1'b0;
              out_run  <= zcnt[3:0];
              out_size <= ac_size;
              out_amp  <= ac_amp;
              zcnt     <= '0;
            end else begin
              // The slot is free now, so the first ZRL goes out with the
              // transfer. The coefficient waits in the latch until the run
              // drops below 16.
              lat_size <= ac_size;
              lat_amp  <= ac_amp;
              ena_out  <= 1'b1;
              out_dc   <= 1'b0;
              out_run  <= 4'd15;
              out_size <= '0;
              out_amp  <= '0;
              zcnt     <= zcnt - 6'd16;
              state    <= S_ZRL;
            end
          end else if (rdy_in) begin
            ena_out <= 1'b0;
          end
        end

        S_ZRL: begin
          if (out_free) begin
            ena_out <= 1'b1;
            out_dc  <= 1'b0;
            if (zcnt[5:4] != 2'b00) begin
              out_run  <= 4'd15;
              out_size <= '0;
              out_amp  <= '0;
              zcnt     <= zcnt - 6'd16;
            end else begin
              out_run  <= zcnt[3:0];
              out_size <= lat_size;
              out_amp  <= lat_amp;
              zcnt     <= '0;
              state    <= S_IN;
            end
          end
        end

        S_EOB: begin
          if (out_free) begin
            ena_out  <= 1'b1;
            out_dc   <= 1'b0;
            out_run  <= 4'd0;
            out_size <= '0;
            out_amp  <= '0;
            zcnt     <= '0;
            state    <= S_IN;
          end
        end

        default: state <= S_IN;
      endcase
    end
  end

endmodule
